// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - multicycle MIPS-subset core with integrated control FSM
// Single shared memory port; memory stalls via mem_ready in FETCH, MEMRD and MEMWR.
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          BNE_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        retire,
  output logic        illegal_instr
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] rf_q [32];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] simm;
  logic [31:0] alu_res;
  logic [31:0] addr_sel;
  logic        op_legal;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign simm   = {{16{ir_q[15]}}, ir_q[15:0]};
  assign pc     = pc_q;
  assign instr  = ir_q;

  always_comb begin
    alu_res = '0;
    case (funct)
      6'h20:   alu_res = a_q + b_q;
      6'h22:   alu_res = a_q - b_q;
      6'h24:   alu_res = a_q & b_q;
      6'h25:   alu_res = a_q | b_q;
      6'h2a:   alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J: op_legal = 1'b1;
      OP_BNE:   op_legal = BNE_EN;
      OP_RTYPE: op_legal = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                           (funct == 6'h25) || (funct == 6'h2a);
      default:  op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    a_d           = a_q;
    b_d           = b_q;
    alu_out_d     = alu_out_q;
    mdr_d         = mdr_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    addr_sel      = pc_q;
    mem_wdata     = b_q;
    retire        = 1'b0;
    illegal_instr = 1'b0;
    rf_we         = 1'b0;
    rf_waddr      = rd;
    rf_wdata      = alu_out_q;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d       = rf_q[rs];
        b_d       = rf_q[rt];
        alu_out_d = pc_q + {simm[29:0], 2'b00};
        if (!op_legal) begin
          illegal_instr = 1'b1;
          retire        = 1'b1;
          state_d       = S_FETCH;
        end else begin
          case (opcode)
            OP_LW, OP_SW:   state_d = S_MEMADR;
            OP_RTYPE:       state_d = S_EXEC;
            OP_ADDI:        state_d = S_ADDIEX;
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            default:        state_d = S_JUMP;
          endcase
        end
      end
      S_MEMADR: begin
        alu_out_d = a_q + simm;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req  = 1'b1;
        addr_sel = alu_out_q;
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = mdr_q;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = alu_out_q;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_out_d = alu_res;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alu_out_d = a_q + simm;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        if ((opcode == OP_BEQ) == (a_q == b_q)) pc_d = alu_out_q;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Whatever state is left over, nothing may leave the core during reset.
    if (reset) begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      retire        = 1'b0;
      illegal_instr = 1'b0;
      rf_we         = 1'b0;
    end
    mem_addr = {addr_sel[31:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule
